// File: rtl/ssd_pkg.sv
// +----------------------------------------------------------------------------+
// | ssd_pkg: seven-segment encodings and digit count shared by driver/decoder |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package ssd_pkg;
   localparam int NUM_DIGITS = 4;

   // active-low gfedcba
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef struct packed {
      logic       legal;
      logic       blank;
      logic [3:0] nibble;
   } seg_dec_t;
endpackage

`default_nettype wire

// File: rtl/ssd_seg_decode.sv
// +----------------------------------------------------------------------------+
// | ssd_seg_decode: combinational active-low segment pattern to hex nibble    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module ssd_seg_decode
   import ssd_pkg::*;
(
   input  logic [6:0] seg_n,
   output seg_dec_t   dec
);

   always_comb begin
      dec.legal  = 1'b1;
      dec.nibble = 4'h0;
      case (seg_n)
         SEG_0:   dec.nibble = 4'h0;
         SEG_1:   dec.nibble = 4'h1;
         SEG_2:   dec.nibble = 4'h2;
         SEG_3:   dec.nibble = 4'h3;
         SEG_4:   dec.nibble = 4'h4;
         SEG_5:   dec.nibble = 4'h5;
         SEG_6:   dec.nibble = 4'h6;
         SEG_7:   dec.nibble = 4'h7;
         SEG_8:   dec.nibble = 4'h8;
         SEG_9:   dec.nibble = 4'h9;
         SEG_A:   dec.nibble = 4'hA;
         SEG_B:   dec.nibble = 4'hB;
         SEG_C:   dec.nibble = 4'hC;
         SEG_D:   dec.nibble = 4'hD;
         SEG_E:   dec.nibble = 4'hE;
         SEG_F:   dec.nibble = 4'hF;
         default: dec.legal  = 1'b0;
      endcase
      dec.blank = (seg_n == SEG_BLANK);
   end

endmodule

`default_nettype wire

// File: rtl/ssd_scan_decoder.sv
// +----------------------------------------------------------------------------+
// | ssd_scan_decoder: recovers 4 hex digits from a multiplexed 7-seg bus.     |
// | Optional decimal-point capture enabled by defining SSD_DECODE_DP_EN.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module ssd_scan_decoder
   import ssd_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int TIMEOUT_W     = 12
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_DIGITS-1:0]     an_n,
   input  logic [6:0]                seg_n,
`ifdef SSD_DECODE_DP_EN
   input  logic                      dp_n,
   output logic [NUM_DIGITS-1:0]     digit_dp,
`endif
   output logic [4*NUM_DIGITS-1:0]   digit_hex,
   output logic [NUM_DIGITS-1:0]     digit_valid,
   output logic [NUM_DIGITS-1:0]     digit_err,
   output logic                      update,
   output logic                      anode_err
);

   localparam int STAB_W = $clog2(STABLE_CYCLES);
   localparam logic [STAB_W-1:0] C_STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
   localparam int AN_LSB = 7;
`ifdef SSD_DECODE_DP_EN
   localparam int SMP_W = NUM_DIGITS + 8;
`else
   localparam int SMP_W = NUM_DIGITS + 7;
`endif

   logic [SMP_W-1:0]            w_smp_in, r_smp, r_smp_prev;
   logic [STAB_W-1:0]           r_stab, w_stab_next;
   logic                        r_captured, w_change, w_capture;
   logic [NUM_DIGITS-1:0]       w_an, w_hit, w_stale;
   logic                        w_an_onehot, w_an_multi, w_upd;
   logic [TIMEOUT_W-1:0]        r_refresh  [NUM_DIGITS];
   logic [TIMEOUT_W-1:0]        w_ref_next [NUM_DIGITS];
   logic [4*NUM_DIGITS-1:0]     r_hex;
   logic [NUM_DIGITS-1:0]       r_valid, r_err;
   logic                        r_update, r_anode_err;
   seg_dec_t                    w_dec;

`ifdef SSD_DECODE_DP_EN
   logic [NUM_DIGITS-1:0]       r_dp;
   assign w_smp_in = {dp_n, an_n, seg_n};
   assign digit_dp = r_dp;
`else
   assign w_smp_in = {an_n, seg_n};
`endif

   ssd_seg_decode u_dec (
      .seg_n (r_smp[6:0]),
      .dec   (w_dec)
   );

   // A dwell captures exactly once, on the edge its stability count reaches the threshold
   always_comb begin
      w_change    = (r_smp != r_smp_prev);
      w_stab_next = w_change ? '0 : ((r_stab == C_STAB_MAX) ? r_stab : r_stab + 1'b1);
      w_capture   = !w_change && (w_stab_next == C_STAB_MAX) && !r_captured;
      w_an        = r_smp[AN_LSB +: NUM_DIGITS];
      w_an_onehot = $onehot(~w_an);
      w_an_multi  = !(&w_an) && !w_an_onehot;
      w_upd       = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_hit[i]      = w_capture && w_an_onehot && !w_an[i];
         w_ref_next[i] = w_hit[i] ? '0 : ((&r_refresh[i]) ? r_refresh[i] : r_refresh[i] + 1'b1);
         w_stale[i]    = &w_ref_next[i];
         if (w_hit[i] && w_dec.legal && (r_hex[4*i +: 4] != w_dec.nibble))
            w_upd = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_smp      <= '1;
         r_smp_prev <= '1;
         r_stab     <= '0;
         r_captured <= 1'b0;
      end else begin
         r_smp      <= w_smp_in;
         r_smp_prev <= r_smp;
         r_stab     <= w_stab_next;
         r_captured <= !w_change && (r_captured || w_capture);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hex       <= '0;
         r_valid     <= '0;
         r_err       <= '0;
         r_update    <= 1'b0;
         r_anode_err <= 1'b0;
`ifdef SSD_DECODE_DP_EN
         r_dp        <= '0;
`endif
         for (int i = 0; i < NUM_DIGITS; i++)
            r_refresh[i] <= '0;
      end else begin
         r_update    <= w_upd;
         r_anode_err <= w_capture && w_an_multi;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            r_refresh[i] <= w_ref_next[i];
            if (w_hit[i]) begin
               if (w_dec.legal) begin
                  r_hex[4*i +: 4] <= w_dec.nibble;
                  r_valid[i]      <= 1'b1;
                  r_err[i]        <= 1'b0;
`ifdef SSD_DECODE_DP_EN
                  r_dp[i]         <= ~r_smp[SMP_W-1];
`endif
               end else begin
                  r_valid[i] <= 1'b0;
                  r_err[i]   <= !w_dec.blank;
               end
            end else if (w_stale[i]) begin
               r_valid[i] <= 1'b0;
            end
         end
      end
   end

   assign digit_hex   = r_hex;
   assign digit_valid = r_valid;
   assign digit_err   = r_err;
   assign update      = r_update;
   assign anode_err   = r_anode_err;

endmodule

`default_nettype wire
